// File: rtl/fq_release.sv
// Receive-side release buffer: holds timestamped flits in arrival order and
// lets each one go once global simulation time has reached its stamp.
module fq_release #(
   parameter int TS_WIDTH   = 10,
   parameter int DATA_WIDTH = 36,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [TS_WIDTH-1:0]   sim_time,
   input  logic                  in_valid,
   input  logic [TS_WIDTH-1:0]   in_ts,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [TS_WIDTH-1:0]   out_ts,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  can_increment,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  order_error
);

   localparam int                  DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] EMPTY = '0;

   logic [TS_WIDTH-1:0]   ts_mem   [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   fill;
   logic [TS_WIDTH-1:0]   head_ts;
   logic [TS_WIDTH-1:0]   last_in_ts;
   logic                  last_valid;
   logic                  err_flag;
   logic                  head_due;
   logic                  enq;
   logic                  deq;

   // Modular "now has reached stamp": the wrapped difference is non-negative.
   function automatic logic ts_reached(input logic [TS_WIDTH-1:0] now,
                                       input logic [TS_WIDTH-1:0] stamp);
      logic signed [TS_WIDTH-1:0] d;
      d = now - stamp;
      return d[TS_WIDTH-1] == 1'b0;
   endfunction

   function automatic logic ts_later(input logic [TS_WIDTH-1:0] a,
                                     input logic [TS_WIDTH-1:0] b);
      return (a != b) && ts_reached(a, b);
   endfunction

   // Only the head entry decides release and time advance.
   always_comb begin
      head_ts       = ts_mem[rd_ptr];
      head_due      = (fill != EMPTY) && ts_reached(sim_time, head_ts);
      can_increment = (fill == EMPTY) || !ts_reached(sim_time, head_ts);
      in_ready      = (fill != FULL);
      out_valid     = head_due;
      out_ts        = head_ts;
      out_data      = data_mem[rd_ptr];
      count         = fill;
      order_error   = err_flag;
      enq           = reset && in_valid && in_ready;
      deq           = reset && head_due && out_ready;
   end

   // Control state: pointers, occupancy and the ordering monitor.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         last_valid <= 1'b0;
         err_flag   <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_valid <= 1'b1;
            if (last_valid && ts_later(last_in_ts, in_ts)) begin
               err_flag <= 1'b1;
            end
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({enq, deq})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // Payload storage and last-seen stamp carry no reset.
   always_ff @(posedge clock) begin
      if (enq) begin
         ts_mem[wr_ptr]   <= in_ts;
         data_mem[wr_ptr] <= in_data;
         last_in_ts       <= in_ts;
      end
   end

endmodule

// File: tb/tb_fq_release.sv
// Bench for fq_release: directed scenarios followed by random traffic, checked
// by a scoreboard queue driven from a timestamp-level reference model.
module tb_fq_release;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  sim_time = '0;
   logic        in_valid = 1'b0;
   logic [9:0]  in_ts = '0;
   logic [35:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [9:0]  out_ts;
   logic [35:0] out_data;
   logic        can_increment;
   logic [3:0]  count;
   logic        order_error;

   typedef struct {
      logic [9:0]  ts;
      logic [35:0] data;
   } flit_t;

   flit_t      sb[$];
   int         total = 0;
   int         bad = 0;
   bit         armed = 0;
   bit         m_last_valid = 0;
   bit         m_err = 0;
   logic [9:0] m_last_ts = '0;

   fq_release #(.TS_WIDTH(10), .DATA_WIDTH(36), .DEPTH_LOG2(3)) dut (
      .clock(clock), .reset(reset), .sim_time(sim_time),
      .in_valid(in_valid), .in_ts(in_ts), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ts(out_ts), .out_data(out_data), .out_ready(out_ready),
      .can_increment(can_increment), .count(count), .order_error(order_error)
   );

   always #5 clock = ~clock;

   // Signed distance from stamp to now on a 1024-tick circle, in [-512, 511].
   function automatic bit reached(input logic [9:0] now, input logic [9:0] stamp);
      int d;
      d = ((int'(now) - int'(stamp)) % 1024 + 1024) % 1024;
      if (d >= 512) d = d - 1024;
      return d >= 0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor/scoreboard: compare against the model, then advance it for the coming edge.
   always @(negedge clock) begin
      int n;
      bit e_ready, e_due, e_ci;
      n       = sb.size();
      e_ready = (n < 8);
      e_due   = (n > 0) ? reached(sim_time, sb[0].ts) : 1'b0;
      e_ci    = (n == 0) ? 1'b1 : !reached(sim_time, sb[0].ts);
      if (armed) begin
         chk("count", 64'(count), 64'(n));
         chk("in_ready", 64'(in_ready), 64'(e_ready));
         chk("out_valid", 64'(out_valid), 64'(e_due));
         chk("can_increment", 64'(can_increment), 64'(e_ci));
         chk("order_error", 64'(order_error), 64'(m_err));
         if (e_due) begin
            chk("out_ts", 64'(out_ts), 64'(sb[0].ts));
            chk("out_data", 64'(out_data), 64'(sb[0].data));
         end
      end
      if (!reset) begin
         sb.delete();
         m_last_valid = 0;
         m_err = 0;
         armed = 1;
      end else if (armed) begin
         if (e_due && out_ready) void'(sb.pop_front());
         if (in_valid && e_ready) begin
            if (m_last_valid && m_last_ts != in_ts && reached(m_last_ts, in_ts)) m_err = 1;
            m_last_ts = in_ts;
            m_last_valid = 1;
            sb.push_back('{ts: in_ts, data: in_data});
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic send(input logic [9:0] ts, input logic [35:0] d);
      bit acc;
      in_valid = 1'b1;
      in_ts    = ts;
      in_data  = d;
      for (int i = 0; i < 40; i++) begin
         acc = in_ready;
         step();
         if (acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      total++;
      bad++;
      $display("FAIL send_timeout: ts %0d not accepted within 40 cycles, acceptance required", ts);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      bit ci;
      // Reset held two cycles with a flit offered.
      reset = 1'b0; in_valid = 1'b1; in_ts = 10'd7; in_data = 36'h7;
      steps(2);
      reset = 1'b1; in_valid = 1'b0;
      steps(2);

      // Single flit, held back then released.
      sim_time = 10'd3;
      send(10'd5, 36'hA);
      step();
      sim_time = 10'd4; step();
      sim_time = 10'd5; steps(3);
      out_ready = 1'b1; step();
      out_ready = 1'b0; steps(2);

      // Fill to full, stall a ninth flit, then drain.
      sim_time = 10'd9;
      for (int i = 0; i < 8; i++) send(10'(10 + i), 36'(i));
      in_valid = 1'b1; in_ts = 10'd18; in_data = 36'd8;
      steps(2);
      sim_time = 10'd20; out_ready = 1'b1;
      send(10'd18, 36'd8);
      steps(12);
      out_ready = 1'b0;

      // Simultaneous enqueue/dequeue at seven, dequeue while full.
      sim_time = 10'd30;
      for (int i = 0; i < 7; i++) send(10'(31 + i), 36'(12'h100 + i));
      sim_time = 10'd31; out_ready = 1'b1;
      in_valid = 1'b1; in_ts = 10'd40; in_data = 36'h200;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      step();
      send(10'd41, 36'h201);
      sim_time = 10'd32; out_ready = 1'b1;
      in_valid = 1'b1; in_ts = 10'd42; in_data = 36'h202;
      step();
      in_valid = 1'b0;
      sim_time = 10'd50;
      steps(10);
      out_ready = 1'b0;

      // Timestamp wrap-around.
      do_reset();
      sim_time = 10'd1020;
      send(10'd1022, 36'h3FE);
      step();
      sim_time = 10'd1021; step();
      sim_time = 10'd1022; step();
      sim_time = 10'd1023; step();
      sim_time = 10'd0;    step();
      out_ready = 1'b1; step();
      out_ready = 1'b0; step();

      // Out-of-order stamps raise the sticky flag; release stays FIFO.
      do_reset();
      sim_time = 10'd30;
      send(10'd50, 36'h50);
      send(10'd40, 36'h40);
      steps(2);
      sim_time = 10'd50; out_ready = 1'b1;
      steps(3);
      out_ready = 1'b0;
      steps(2);
      do_reset();
      steps(2);

      // Random traffic with occasional mid-stream resets.
      sim_time = 10'd900;
      for (int c = 0; c < 800; c++) begin
         reset     = ($urandom_range(0, 299) != 0);
         in_valid  = $urandom_range(0, 1) == 1;
         in_ts     = sim_time + 10'($urandom_range(0, 20));
         in_data   = 36'({$urandom(), $urandom()});
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         ci = can_increment;
         step();
         if (ci && $urandom_range(0, 1) == 1) sim_time = sim_time + 10'd1;
      end
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      steps(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
